pcie_piso_multilane: RTL and testbench

//  Multi-lane parallel-in/serial-out transmitter shifter for the PCIe TX path: takes one symbol per

---
 rtl/pcie_serdes_pkg.sv | 20 ++
 rtl/pcie_piso_lane.sv | 50 +++++
 rtl/pcie_piso_multilane.sv | 122 ++++++++++++
 tb/tb_pcie_piso_multilane.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_serdes_pkg.sv
// Shared definitions for the PCIe TX serializer blocks.
//   SYM_WIDTH_DEF / NUM_LANES_DEF : default symbol width and lane count
//   cnt_width()                   : bit counter width for a given symbol width
//   piso_state_e                  : shifter control state (IDLE / SHIFT)
package pcie_serdes_pkg;

    localparam int SYM_WIDTH_DEF = 10;
    localparam int NUM_LANES_DEF = 4;

    // Counter has to hold 0..sym_width-1.
    function automatic int cnt_width(input int sym_width);
        return (sym_width < 2) ? 1 : $clog2(sym_width);
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

endpackage

// File: rtl/pcie_piso_lane.sv
// One lane of the multi-lane PISO: holding register, shift register and
// gated serial output. All sequencing decisions come from the shared
// control in pcie_piso_multilane.
//   clk, reset : clock, synchronous active-high reset (clears both registers)
//   hold_we    : capture sym into the holding register
//   load       : copy holding register into the shifter
//   shift      : advance the shifter one bit toward the output position
//   oe         : output enable; ser is forced low when clear
//   sym        : this lane's incoming symbol
//   ser        : this lane's serial bit
module pcie_piso_lane
    import pcie_serdes_pkg::*;
#(
    parameter int SYM_WIDTH = SYM_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold_we,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 oe,
    input  logic [SYM_WIDTH-1:0] sym,
    output logic                 ser
);

    localparam int OUT_POS = MSB_FIRST ? SYM_WIDTH - 1 : 0;

    logic [SYM_WIDTH-1:0] hold_q;
    logic [SYM_WIDTH-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            shift_q <= '0;
        end else begin
            if (hold_we)
                hold_q <= sym;
            if (load)
                shift_q <= hold_q;
            else if (shift)
                // Zero fill so a drained shifter never replays stale bits.
                shift_q <= MSB_FIRST ? {shift_q[SYM_WIDTH-2:0], 1'b0}
                                     : {1'b0, shift_q[SYM_WIDTH-1:1]};
        end
    end

    assign ser = oe & shift_q[OUT_POS];

endmodule

// File: rtl/pcie_piso_multilane.sv
// Multi-lane parallel-in/serial-out TX shifter. Accepts one symbol per lane
// over valid/ready into a one-entry holding buffer and shifts all lanes out
// in lockstep; a queued symbol is reloaded on the last bit so back-to-back
// symbols leave without a gap.
//   clk, reset : clock, synchronous active-high reset
//   enable     : 1 shift, 0 freeze (outputs quiet, hold may still fill)
//   s_valid    : symbol group valid
//   s_ready    : holding buffer empty
//   s_data     : lane i at s_data[i*SYM_WIDTH +: SYM_WIDTH]
//   ser_out    : serial bit per lane
//   ser_oe     : pad drive enable
//   sym_start  : first bit of a symbol on ser_out
//   underrun   : last bit out with nothing queued behind it
//   busy       : shifter active or holding buffer full
module pcie_piso_multilane
    import pcie_serdes_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int SYM_WIDTH = SYM_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [NUM_LANES*SYM_WIDTH-1:0] s_data,
    output logic [NUM_LANES-1:0]           ser_out,
    output logic                           ser_oe,
    output logic                           sym_start,
    output logic                           underrun,
    output logic                           busy
);

    localparam int              CW       = cnt_width(SYM_WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SYM_WIDTH - 1);

    piso_state_e   state;
    piso_state_e   state_nxt;
    logic [CW-1:0] cnt;
    logic          hold_valid;
    logic          accept;
    logic          load;
    logic          shift;

    assign s_ready   = !hold_valid;
    assign accept    = s_valid && s_ready;
    assign ser_oe    = enable && (state == SHIFT);
    assign sym_start = ser_oe && (cnt == '0);
    assign busy      = (state == SHIFT) || hold_valid;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        underrun  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && hold_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    if (cnt != CNT_LAST) begin
                        shift = 1'b1;
                    end else if (hold_valid) begin
                        // Zero-bubble reload on the last bit.
                        load = 1'b1;
                    end else begin
                        underrun  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load and accept never coincide: a load needs hold_valid, which blocks s_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (load || underrun)
                cnt <= '0;
            else if (shift)
                cnt <= cnt + CW'(1);

            if (load)
                hold_valid <= 1'b0;
            else if (accept)
                hold_valid <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pcie_piso_lane #(
            .SYM_WIDTH (SYM_WIDTH),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .hold_we (accept),
            .load    (load),
            .shift   (shift),
            .oe      (ser_oe),
            .sym     (s_data[i*SYM_WIDTH +: SYM_WIDTH]),
            .ser     (ser_out[i])
        );
    end

endmodule

// File: tb/tb_pcie_piso_multilane.sv
// Bench for pcie_piso_multilane: an MSB-first 2-lane instance checked every
// cycle against a symbol-queue reference model, plus an LSB-first instance
// for bit-order checks.
module tb_pcie_piso_multilane;

    localparam int NL = 2;
    localparam int W  = 10;

    logic          clk = 1'b0;
    logic          reset, enable, s_valid;
    logic [NL*W-1:0] s_data;
    logic          s_ready, ser_oe, sym_start, underrun, busy;
    logic [NL-1:0] ser_out;

    logic          b_reset, b_enable, b_valid;
    logic [NL*W-1:0] b_data;
    logic          b_ready, b_oe, b_start, b_under, b_busy;
    logic [NL-1:0] b_ser;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcie_piso_multilane #(.NUM_LANES(NL), .SYM_WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .ser_out(ser_out), .ser_oe(ser_oe), .sym_start(sym_start),
        .underrun(underrun), .busy(busy)
    );

    pcie_piso_multilane #(.NUM_LANES(NL), .SYM_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(b_reset), .enable(b_enable), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_data), .ser_out(b_ser), .ser_oe(b_oe), .sym_start(b_start),
        .underrun(b_under), .busy(b_busy)
    );

    // Reference model: a pending-symbol queue (at most one entry), the symbol
    // being transmitted and the index of the bit currently on the wire.
    logic [NL*W-1:0] m_hold[$];
    logic [NL*W-1:0] m_cur;
    bit              m_cur_v = 1'b0;
    int              m_idx   = 0;

    always @(posedge clk) begin
        bit hv;
        if (reset) begin
            m_hold.delete();
            m_cur_v = 1'b0;
            m_idx   = 0;
        end else begin
            hv = (m_hold.size() != 0);
            if (enable) begin
                if (m_cur_v) begin
                    if (m_idx == W - 1) begin
                        if (hv) begin
                            m_cur = m_hold.pop_front();
                            m_idx = 0;
                        end else begin
                            m_cur_v = 1'b0;
                        end
                    end else begin
                        m_idx++;
                    end
                end else if (hv) begin
                    m_cur   = m_hold.pop_front();
                    m_idx   = 0;
                    m_cur_v = 1'b1;
                end
            end
            if (s_valid && !hv)
                m_hold.push_back(s_data);
        end
    end

    wire [NL+4:0] obs = {s_ready, ser_oe, sym_start, underrun, busy, ser_out};

    // {s_ready, ser_oe, sym_start, underrun, busy, ser_out} predicted from the model.
    function automatic logic [NL+4:0] exp_vec();
        logic [NL-1:0] so;
        logic oe;
        int pos;
        oe  = enable && m_cur_v;
        pos = W - 1 - m_idx;
        for (int i = 0; i < NL; i++)
            so[i] = oe ? m_cur[i*W + pos] : 1'b0;
        return {(m_hold.size() == 0), oe, oe && (m_idx == 0),
                oe && (m_idx == W - 1) && (m_hold.size() == 0),
                m_cur_v || (m_hold.size() != 0), so};
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
        b_reset = 1'b1; b_enable = 1'b0; b_valid = 1'b0; b_data = '0;
        repeat (3) @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        total++; if (ser_oe !== 1'b0) begin bad++; $display("FAIL reset_ser_oe: got %b want 0", ser_oe); end
        total++; if (ser_out !== 2'b00) begin bad++; $display("FAIL reset_ser_out: got %b want 00", ser_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release: got %b want %b", obs, exp_vec()); end
    endtask

    task automatic test_single();
        logic [W-1:0] w0, w1;
        int nbit, first_c, start_pos, under_pos;
        w0 = '0; w1 = '0; nbit = 0; first_c = -1; start_pos = -1; under_pos = -1;
        enable = 1'b1; s_valid = 1'b1; s_data = {10'h155, 10'h2AA};
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL single c%0d: got %b want %b", c, obs, exp_vec()); end
            if (c == 1) s_valid = 1'b0;
            if (ser_oe) begin
                if (first_c < 0) first_c = c;
                if (sym_start) start_pos = nbit;
                if (underrun) under_pos = nbit;
                w0 = {w0[W-2:0], ser_out[0]};
                w1 = {w1[W-2:0], ser_out[1]};
                nbit++;
            end
        end
        total++; if (first_c !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", first_c); end
        total++; if (w0 !== 10'h2AA) begin bad++; $display("FAIL single_lane0: got %b want %b", w0, 10'h2AA); end
        total++; if (w1 !== 10'h155) begin bad++; $display("FAIL single_lane1: got %b want %b", w1, 10'h155); end
        total++; if (nbit !== 10) begin bad++; $display("FAIL single_nbits: got %0d want 10", nbit); end
        total++; if (start_pos !== 0) begin bad++; $display("FAIL single_start: got %0d want 0", start_pos); end
        total++; if (under_pos !== 9) begin bad++; $display("FAIL single_underrun: got %0d want 9", under_pos); end
    endtask

    task automatic test_back_to_back();
        logic [NL*W-1:0] g[3];
        logic [29:0] stream, starts;
        int sent, nbit, gaps, nunder, under_pos;
        bit acc;
        g[0] = {10'h3FF, 10'h3FF}; g[1] = {10'h000, 10'h000}; g[2] = {10'h3FF, 10'h3FF};
        stream = '0; starts = '0; sent = 0; nbit = 0; gaps = 0; nunder = 0; under_pos = -1;
        s_valid = 1'b1; s_data = g[0];
        for (int c = 1; c <= 45; c++) begin
            acc = s_valid && (m_hold.size() == 0);
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL b2b c%0d: got %b want %b", c, obs, exp_vec()); end
            if (acc) begin
                sent++;
                if (sent < 3) s_data = g[sent];
                else s_valid = 1'b0;
            end
            if (ser_oe) begin
                if (sym_start && nbit < 30) starts[nbit] = 1'b1;
                if (underrun) begin nunder++; under_pos = nbit; end
                stream = {stream[28:0], ser_out[0]};
                nbit++;
            end else if (nbit > 0 && nbit < 30) begin
                gaps++;
            end
        end
        total++; if (nbit !== 30) begin bad++; $display("FAIL b2b_nbits: got %0d want 30", nbit); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
        total++; if (stream !== 30'h3FF003FF) begin bad++; $display("FAIL b2b_stream: got %h want %h", stream, 30'h3FF003FF); end
        total++; if (starts !== 30'h00100401) begin bad++; $display("FAIL b2b_starts: got %h want %h", starts, 30'h00100401); end
        total++; if (nunder !== 1 || under_pos !== 29) begin bad++; $display("FAIL b2b_underrun: got n=%0d pos=%0d want n=1 pos=29", nunder, under_pos); end
    endtask

    task automatic test_enable_pause();
        logic [W-1:0] w0;
        int nbit;
        bit paused, check_resume;
        w0 = '0; nbit = 0; paused = 1'b0; check_resume = 1'b0;
        s_valid = 1'b1; s_data = {10'h155, 10'h2AA};
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL pause c%0d: got %b want %b", c, obs, exp_vec()); end
            if (c == 1) s_valid = 1'b0;
            if (ser_oe) begin
                if (check_resume) begin
                    check_resume = 1'b0;
                    total++; if (ser_out[0] !== 1'b1 || nbit !== 4) begin bad++; $display("FAIL pause_resume: got bit=%b idx=%0d want bit=1 idx=4", ser_out[0], nbit); end
                end
                w0 = {w0[W-2:0], ser_out[0]};
                nbit++;
            end
            if (ser_oe && nbit == 4 && !paused) begin
                paused = 1'b1;
                @(posedge clk); #1 enable = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    @(negedge clk);
                    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL pause_frozen: got %b want %b", obs, exp_vec()); end
                    total++; if (ser_oe !== 1'b0 || ser_out !== 2'b00) begin bad++; $display("FAIL pause_quiet: got oe=%b out=%b want oe=0 out=00", ser_oe, ser_out); end
                end
                @(posedge clk); #1 enable = 1'b1;
                check_resume = 1'b1;
            end
        end
        total++; if (w0 !== 10'h2AA || nbit !== 10) begin bad++; $display("FAIL pause_word: got %b n=%0d want %b n=10", w0, nbit, 10'h2AA); end
    endtask

    task automatic test_reset_mid();
        int sent, nbit, oe_after;
        bit acc, did;
        sent = 0; nbit = 0; oe_after = 0; did = 1'b0;
        s_valid = 1'b1; s_data = {10'h155, 10'h2AA};
        for (int c = 1; c <= 30; c++) begin
            acc = s_valid && (m_hold.size() == 0);
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL rstmid c%0d: got %b want %b", c, obs, exp_vec()); end
            if (acc) begin
                sent++;
                if (sent == 1) s_data = {10'h3FF, 10'h3FF};
                else s_valid = 1'b0;
            end
            if (ser_oe) begin
                if (did) oe_after++;
                nbit++;
            end
            if (ser_oe && nbit == 7 && !did) begin
                did = 1'b1;
                total++; if (busy !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL rstmid_hold_full: got busy=%b rdy=%b want busy=1 rdy=0", busy, s_ready); end
                reset = 1'b1;
                @(negedge clk);
                total++; if (obs !== {1'b1, 4'b0000, 2'b00}) begin bad++; $display("FAIL rstmid_outputs: got %b want %b", obs, {1'b1, 4'b0000, 2'b00}); end
                reset = 1'b0;
            end
        end
        total++; if (oe_after !== 0) begin bad++; $display("FAIL rstmid_stale: got %0d bits want 0", oe_after); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            enable  = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = NL*W'($urandom);
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL random c%0d: got %b want %b", c, obs, exp_vec()); end
        end
        reset = 1'b0; enable = 1'b1; s_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            total++; if (obs !== exp_vec()) begin bad++; $display("FAIL random_drain c%0d: got %b want %b", c, obs, exp_vec()); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL random_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] q0, q1;
        int k;
        q0 = '0; q1 = '0; k = 0;
        b_reset = 1'b0;
        @(negedge clk);
        b_enable = 1'b1; b_valid = 1'b1; b_data = {10'h3FE, 10'h001};
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) b_valid = 1'b0;
            if (b_oe) begin
                if (k < W) begin q0[k] = b_ser[0]; q1[k] = b_ser[1]; end
                k++;
            end
        end
        total++; if (k !== 10) begin bad++; $display("FAIL lsb_nbits: got %0d want 10", k); end
        total++; if (q0 !== 10'h001) begin bad++; $display("FAIL lsb_lane0: got %b want %b", q0, 10'h001); end
        total++; if (q1 !== 10'h3FE) begin bad++; $display("FAIL lsb_lane1: got %b want %b", q1, 10'h3FE); end
        total++; if (b_busy !== 1'b0 || b_oe !== 1'b0) begin bad++; $display("FAIL lsb_idle: got busy=%b oe=%b want 0 0", b_busy, b_oe); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_pause();
        test_reset_mid();
        test_random();
        test_lsb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
